timing_sequence_decoder: RTL and testbench

- Parametrised successor to the combinational 4-to-16 decoder: a sequence counter (SC) fused with an N-to-2^N one-hot decoder.
- Produces the T0..T(2^N-1) timing signals that step the control unit through fetch/decode/execute.
- Adds the behaviour the plain decoder lacks: clear, increment, parallel load, programmable wrap point, a wrap pulse and a load-error flag.

---
 rtl/timing_pkg.sv | 21 ++
 rtl/nbit_onehot_decoder.sv | 20 ++
 rtl/timing_sequence_decoder.sv | 81 ++++++++
 tb/tb_timing_sequence_decoder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/timing_pkg.sv
// Shared constants for the control-unit timing sequence counter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package timing_pkg;

  // Default counter width and wrap point: a 4-bit SC cycling T0..T15.
  localparam int DEF_CODE_W    = 4;
  localparam int DEF_MAX_COUNT = 15;

  // Timing-step indices the control unit keys fetch/decode on.
  localparam int T0_IDX = 0;
  localparam int T1_IDX = 1;
  localparam int T2_IDX = 2;
  localparam int T3_IDX = 3;

  // One-hot output width for a given code width.
  function automatic int out_width(input int code_w);
    return 1 << code_w;
  endfunction

endpackage

// File: rtl/nbit_onehot_decoder.sv
// Purpose: combinational N-to-2^N one-hot decoder (timing steps, opcode D0..D7).
// Latency: zero cycles, purely combinational.
// Backpressure: none; output follows the code input directly.
// Ports: code    - binary index to decode
//        onehot  - onehot[k] = 1 iff code == k
module nbit_onehot_decoder
  import timing_pkg::*;
#(
  parameter int CODE_W = 3
) (
  input  logic [CODE_W-1:0]            code,
  output logic [out_width(CODE_W)-1:0] onehot
);

  always_comb begin
    onehot       = '0;
    onehot[code] = 1'b1;
  end

endmodule

// File: rtl/timing_sequence_decoder.sv
// Purpose: sequence counter fused with a one-hot decoder, producing T0..T(2^N-1).
// Latency: count/times/wrap/load_err all registered, updating on the same clk edge.
// Backpressure: none; clr > load > inc > hold is evaluated every cycle.
// Ports: clk, rst_n (async active-low); clr/load/inc/load_val controls;
//        count (SC value), times (one-hot of count), wrap (pulse after
//        MAX_COUNT -> 0 via inc), load_err (sticky out-of-range load).
module timing_sequence_decoder
  import timing_pkg::*;
#(
  parameter int CODE_W    = DEF_CODE_W,
  parameter int MAX_COUNT = DEF_MAX_COUNT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         inc,
  input  logic                         load,
  input  logic [CODE_W-1:0]            load_val,
  output logic [CODE_W-1:0]            count,
  output logic [out_width(CODE_W)-1:0] times,
  output logic                         wrap,
  output logic                         load_err
);

  localparam int                OUT_W = out_width(CODE_W);
  localparam logic [CODE_W-1:0] MAX_C = CODE_W'(MAX_COUNT);

  logic [CODE_W-1:0] next_count;
  logic [OUT_W-1:0]  next_times;
  logic              next_wrap;
  logic              next_err;

  // Next-state selection; wrap only ever comes from an inc rolling over.
  always_comb begin
    next_count = count;
    next_wrap  = 1'b0;
    next_err   = load_err;
    if (clr) begin
      next_count = '0;
      next_err   = 1'b0;
    end else if (load) begin
      if (load_val > MAX_C) begin
        next_count = '0;
        next_err   = 1'b1;
      end else begin
        next_count = load_val;
      end
    end else if (inc) begin
      if (count == MAX_C) begin
        next_count = '0;
        next_wrap  = 1'b1;
      end else begin
        next_count = count + 1'b1;
      end
    end
  end

  // Decoding the next count lets times register on the same edge as count,
  // so times == 1 << count holds without an extra pipeline stage.
  nbit_onehot_decoder #(
    .CODE_W (CODE_W)
  ) u_dec (
    .code   (next_count),
    .onehot (next_times)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      times    <= OUT_W'(1);
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count    <= next_count;
      times    <= next_times;
      wrap     <= next_wrap;
      load_err <= next_err;
    end
  end

endmodule

// File: tb/tb_timing_sequence_decoder.sv
// Bench for timing_sequence_decoder: three instances (MAX_COUNT 15, 5, 11)
// share one stimulus stream and are compared against a per-instance model.
module tb_timing_sequence_decoder;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        inc;
  logic        load;
  logic [3:0]  load_val;

  logic [3:0]  cnt   [3];
  logic [15:0] tms   [3];
  logic        wrp   [3];
  logic        lerr  [3];

  int checks = 0;
  int errors = 0;

  // Reference model state, one entry per instance.
  int m_max [3] = '{15, 5, 11};
  int m_cnt [3];
  bit m_wrap[3];
  bit m_err [3];

  timing_sequence_decoder #(.CODE_W(4), .MAX_COUNT(15)) u_dut15 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc), .load(load),
    .load_val(load_val), .count(cnt[0]), .times(tms[0]), .wrap(wrp[0]),
    .load_err(lerr[0]));

  timing_sequence_decoder #(.CODE_W(4), .MAX_COUNT(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc), .load(load),
    .load_val(load_val), .count(cnt[1]), .times(tms[1]), .wrap(wrp[1]),
    .load_err(lerr[1]));

  timing_sequence_decoder #(.CODE_W(4), .MAX_COUNT(11)) u_dut11 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc), .load(load),
    .load_val(load_val), .count(cnt[2]), .times(tms[2]), .wrap(wrp[2]),
    .load_err(lerr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.i%0d.count", where, k), 32'(cnt[k]), 32'(m_cnt[k]));
      chk($sformatf("%s.i%0d.times", where, k), 32'(tms[k]), 32'(1) << m_cnt[k]);
      chk($sformatf("%s.i%0d.wrap", where, k), 32'(wrp[k]), 32'(m_wrap[k]));
      chk($sformatf("%s.i%0d.load_err", where, k), 32'(lerr[k]), 32'(m_err[k]));
      chk($sformatf("%s.i%0d.popcount", where, k), 32'($countones(tms[k])), 32'd1);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k]  = 0;
      m_wrap[k] = 1'b0;
      m_err[k]  = 1'b0;
    end
  endtask

  // Behavioural rules: clr wins, then load (range-checked), then inc modulo MAX+1.
  task automatic model_step(input bit c, input bit l, input bit i, input int v);
    for (int k = 0; k < 3; k++) begin
      m_wrap[k] = 1'b0;
      if (c) begin
        m_cnt[k] = 0;
        m_err[k] = 1'b0;
      end else if (l) begin
        if (v <= m_max[k]) m_cnt[k] = v;
        else begin
          m_cnt[k] = 0;
          m_err[k] = 1'b1;
        end
      end else if (i) begin
        m_cnt[k]  = (m_cnt[k] + 1) % (m_max[k] + 1);
        m_wrap[k] = (m_cnt[k] == 0);
      end
    end
  endtask

  // Inputs are driven 1 time unit after an edge; outputs sampled 1 after the next.
  task automatic step(input string where, input bit c, input bit l, input bit i, input int v);
    clr      = c;
    load     = l;
    inc      = i;
    load_val = 4'(v);
    @(posedge clk);
    #1;
    model_step(c, l, i, v);
    clr  = 1'b0;
    load = 1'b0;
    inc  = 1'b0;
    check_all(where);
  endtask

  initial begin
    rst_n    = 1'b0;
    clr      = 1'b0;
    inc      = 1'b0;
    load     = 1'b0;
    load_val = '0;
    model_reset();

    // Reset state held across clock edges.
    #12;
    check_all("reset");
    #1 rst_n = 1'b1;

    // 16 increments: full T0..T15 walk on the default instance.
    for (int n = 0; n < 16; n++) step($sformatf("inc16_%0d", n), 0, 0, 1, 0);
    step("idle_after_wrap", 0, 0, 0, 0);

    // Held inc from 0 for 8 cycles (MAX=5 sequence 1..5,0,1,2).
    step("clr_a", 1, 0, 0, 0);
    for (int n = 0; n < 8; n++) step($sformatf("inc8_%0d", n), 0, 0, 1, 0);

    // Parallel load then increment.
    step("clr_b", 1, 0, 0, 0);
    step("load9", 0, 1, 0, 9);
    step("load9_inc", 0, 0, 1, 0);

    // Out-of-range load, sticky error through incs, cleared by clr.
    step("load13", 0, 1, 0, 13);
    for (int n = 0; n < 3; n++) step($sformatf("err_inc_%0d", n), 0, 0, 1, 0);
    step("err_clr", 1, 0, 0, 0);

    // Priority: clr over load/inc, load over inc.
    step("load6", 0, 1, 0, 6);
    step("clr_load_inc", 1, 1, 1, 3);
    step("load_inc", 0, 1, 1, 3);

    // Load at MAX with inc also high must not produce wrap.
    step("load15_inc", 0, 1, 1, 15);
    step("load0_at_max", 0, 1, 0, 0);

    // Asynchronous reset in the middle of the cycle at T7.
    step("load7", 0, 1, 0, 7);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    rst_n = 1'b1;
    step("after_rst", 0, 0, 0, 0);

    // Randomised control mix.
    for (int n = 0; n < 200; n++) begin
      bit c, l, i;
      int v;
      c = ($urandom_range(0, 15) == 0);
      l = ($urandom_range(0, 7) == 0);
      i = ($urandom_range(0, 1) == 1);
      v = int'($urandom_range(0, 15));
      step($sformatf("rand_%0d", n), c, l, i, v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
